// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result and control, owns the N/Z flag
// register, resolves conditional branches and squashes the branch shadow.
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4,
  parameter int SHADOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_flag_n,
  input  logic              alu_flag_z,
  input  logic              ex_set_flags,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [2:0]        ex_br_cond,
  input  logic [DATA_W-1:0] ex_br_target,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [RD_W-1:0]   mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_br_taken,
  output logic [DATA_W-1:0] mem_br_target,
  output logic              flag_n,
  output logic              flag_z,
  output logic [15:0]       retired_count
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic              bt_q, bt_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_z_q, flag_z_d;
  logic [15:0]       ret_q, ret_d;
  logic [1:0]        shadow_q, shadow_d;
  logic              cond_true;
  logic              accept;

  // Conditions look at the flag register before this edge's update.
  always_comb begin
    cond_true = 1'b0;
    case (ex_br_cond)
      3'b000: cond_true = 1'b0;
      3'b001: cond_true = 1'b1;
      3'b010: cond_true = flag_z_q;
      3'b011: cond_true = ~flag_z_q;
      3'b100: cond_true = flag_n_q;
      3'b101: cond_true = ~flag_n_q;
      3'b110: cond_true = ~flag_n_q & ~flag_z_q;
      3'b111: cond_true = flag_n_q | flag_z_q;
      default: cond_true = 1'b0;
    endcase
  end

  assign accept = ex_valid & (shadow_q == 2'd0) & ~stall & ~flush;

  always_comb begin
    valid_d  = valid_q;
    alu_d    = alu_q;
    sdata_d  = sdata_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    bt_d     = bt_q;
    tgt_d    = tgt_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    ret_d    = ret_q;
    shadow_d = shadow_q;
    if (!stall) begin
      // Default to a bubble; accepted slots overwrite every field below.
      valid_d = 1'b0;
      alu_d   = '0;
      sdata_d = '0;
      rd_d    = '0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      bt_d    = 1'b0;
      tgt_d   = '0;
      if (flush) begin
        shadow_d = 2'd0;
      end else if (accept) begin
        valid_d  = 1'b1;
        alu_d    = alu_result;
        sdata_d  = ex_store_data;
        rd_d     = ex_rd;
        rw_d     = ex_reg_write;
        mr_d     = ex_mem_read;
        mw_d     = ex_mem_write;
        bt_d     = cond_true;
        tgt_d    = ex_br_target;
        ret_d    = ret_q + 16'd1;
        shadow_d = cond_true ? 2'(SHADOW) : 2'd0;
        if (ex_set_flags) begin
          flag_n_d = alu_flag_n;
          flag_z_d = alu_flag_z;
        end
      end else if (ex_valid && shadow_q != 2'd0) begin
        shadow_d = shadow_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      sdata_q  <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      bt_q     <= 1'b0;
      tgt_q    <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      ret_q    <= '0;
      shadow_q <= 2'd0;
    end else begin
      valid_q  <= valid_d;
      alu_q    <= alu_d;
      sdata_q  <= sdata_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      bt_q     <= bt_d;
      tgt_q    <= tgt_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      ret_q    <= ret_d;
      shadow_q <= shadow_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_result = alu_q;
  assign mem_store_data = sdata_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = rw_q & valid_q;
  assign mem_mem_read   = mr_q & valid_q;
  assign mem_mem_write  = mw_q & valid_q;
  assign mem_br_taken   = bt_q;
  assign mem_br_target  = tgt_q;
  assign flag_n         = flag_n_q;
  assign flag_z         = flag_z_q;
  assign retired_count  = ret_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed table-driven bench for ex_mem_stage plus hand-written reset and
// counter-wrap sequences.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid;
  logic [15:0] alu_result, ex_store_data, ex_br_target;
  logic        alu_flag_n, alu_flag_z, ex_set_flags;
  logic [3:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_br_cond;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_br_taken;
  logic [15:0] mem_alu_result, mem_store_data, mem_br_target, retired_count;
  logic [3:0]  mem_rd;
  logic        flag_n, flag_z;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(16), .RD_W(4), .SHADOW(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .alu_result(alu_result), .alu_flag_n(alu_flag_n), .alu_flag_z(alu_flag_z),
    .ex_set_flags(ex_set_flags), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .ex_br_cond(ex_br_cond),
    .ex_br_target(ex_br_target), .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_br_taken(mem_br_taken),
    .mem_br_target(mem_br_target), .flag_n(flag_n), .flag_z(flag_z),
    .retired_count(retired_count)
  );

  typedef struct packed {
    logic v; logic [15:0] alu; logic [15:0] sd; logic [3:0] rd;
    logic rw; logic mr; logic mw; logic bt; logic [15:0] tgt;
    logic n; logic z; logic [15:0] ret;
  } out_t;

  typedef struct {
    logic stall; logic flush; logic v; logic [15:0] alu; logic n; logic z; logic sf;
    logic [3:0] rd; logic rw; logic mr; logic mw; logic [15:0] sd; logic [2:0] cond;
    logic [15:0] tgt;
    // expected: slot accepted, branch pulse, flags, retired count
    logic e_v; logic e_bt; logic e_n; logic e_z; logic [15:0] e_ret;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  vec_t vecs[31];
  out_t exp_o, prev_o, got;

  function automatic out_t sample();
    out_t o;
    o = '{mem_valid, mem_alu_result, mem_store_data, mem_rd, mem_reg_write,
          mem_mem_read, mem_mem_write, mem_br_taken, mem_br_target,
          flag_n, flag_z, retired_count};
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t g;
    g = sample();
    tests++;
    if (g !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, g, exp);
    end else begin
      $display("ok   %s: %h", name, g);
    end
  endtask

  task automatic drive_idle();
    stall = 0; flush = 0; ex_valid = 0; alu_result = 0; alu_flag_n = 0; alu_flag_z = 0;
    ex_set_flags = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_store_data = 0; ex_br_cond = 0; ex_br_target = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           st fl v  alu      n  z  sf rd rw mr mw sd       cond    tgt        e_v bt n  z  ret
    vecs[0]  = '{0, 0, 1, 16'h0005, 0, 0, 1, 3, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 1, 0, 0, 0, 16'd1};
    vecs[1]  = '{0, 0, 1, 16'h0000, 0, 1, 1, 4, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 1, 0, 0, 1, 16'd2};
    vecs[2]  = '{0, 0, 1, 16'h1111, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b010, 16'h0040, 1, 1, 0, 1, 16'd3};
    vecs[3]  = '{0, 0, 1, 16'h2222, 0, 0, 0, 5, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 0, 0, 0, 1, 16'd3};
    vecs[4]  = '{0, 0, 1, 16'h3333, 0, 0, 0, 6, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 1, 0, 0, 1, 16'd4};
    vecs[5]  = '{1, 0, 1, 16'hAAAA, 1, 0, 1, 7, 1, 1, 1, 16'h1234, 3'b001, 16'h0500, 1, 0, 0, 1, 16'd4};
    vecs[6]  = '{1, 0, 1, 16'hAAAB, 1, 1, 1, 8, 1, 1, 1, 16'h5678, 3'b001, 16'h0510, 1, 0, 0, 1, 16'd4};
    vecs[7]  = '{1, 0, 0, 16'hAAAC, 0, 0, 0, 9, 0, 0, 0, 16'h9ABC, 3'b000, 16'h0520, 1, 0, 0, 1, 16'd4};
    vecs[8]  = '{0, 1, 1, 16'hBBBB, 1, 0, 1, 8, 1, 0, 0, 16'h0000, 3'b001, 16'h0600, 0, 0, 0, 1, 16'd4};
    vecs[9]  = '{1, 1, 1, 16'hCCCC, 1, 0, 1, 8, 1, 0, 0, 16'h0000, 3'b001, 16'h0610, 0, 0, 0, 1, 16'd4};
    vecs[10] = '{0, 0, 1, 16'h0007, 1, 0, 0, 1, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 1, 0, 0, 1, 16'd5};
    vecs[11] = '{0, 0, 1, 16'h0008, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b100, 16'h0080, 1, 0, 0, 1, 16'd6};
    vecs[12] = '{0, 0, 1, 16'h0009, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b011, 16'h0090, 1, 0, 0, 1, 16'd7};
    vecs[13] = '{0, 0, 1, 16'h000A, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b101, 16'h00A0, 1, 1, 0, 1, 16'd8};
    vecs[14] = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b000, 16'h0000, 0, 0, 0, 1, 16'd8};
    vecs[15] = '{0, 0, 1, 16'h4444, 0, 0, 0, 2, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 0, 0, 0, 1, 16'd8};
    vecs[16] = '{0, 0, 1, 16'h5555, 0, 0, 0, 2, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 1, 0, 0, 1, 16'd9};
    vecs[17] = '{0, 0, 1, 16'h8000, 1, 0, 1, 9, 1, 0, 0, 16'h0000, 3'b110, 16'h00B0, 1, 0, 1, 0, 16'd10};
    vecs[18] = '{0, 0, 1, 16'h000C, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b100, 16'h0100, 1, 1, 1, 0, 16'd11};
    vecs[19] = '{0, 0, 1, 16'h0200, 0, 0, 0, 7, 1, 1, 0, 16'h0000, 3'b000, 16'h0000, 0, 0, 1, 0, 16'd11};
    vecs[20] = '{0, 0, 1, 16'h0210, 0, 0, 0, 0, 0, 0, 1, 16'hBEEF, 3'b000, 16'h0000, 1, 0, 1, 0, 16'd12};
    vecs[21] = '{0, 0, 1, 16'h0011, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b111, 16'h0300, 1, 1, 1, 0, 16'd13};
    vecs[22] = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b000, 16'h0000, 0, 0, 1, 0, 16'd13};
    vecs[23] = '{0, 1, 1, 16'h0022, 0, 0, 0, 3, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 0, 0, 1, 0, 16'd13};
    vecs[24] = '{0, 0, 1, 16'h0001, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 1, 0, 1, 0, 16'd14};
    vecs[25] = '{0, 0, 1, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b001, 16'h0400, 1, 1, 1, 0, 16'd15};
    vecs[26] = '{1, 0, 1, 16'h0033, 0, 0, 0, 4, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 1, 1, 1, 0, 16'd15};
    vecs[27] = '{0, 0, 1, 16'h0003, 0, 0, 0, 4, 1, 0, 0, 16'h0000, 3'b000, 16'h0000, 0, 0, 1, 0, 16'd15};
    vecs[28] = '{0, 0, 1, 16'h0004, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b000, 16'h0500, 1, 0, 1, 0, 16'd16};
    vecs[29] = '{0, 0, 1, 16'h0006, 0, 0, 1, 5, 1, 0, 0, 16'h0000, 3'b010, 16'h0580, 1, 0, 0, 0, 16'd17};
    vecs[30] = '{0, 0, 1, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 3'b111, 16'h0600, 1, 0, 0, 0, 16'd18};

    // Reset held two cycles with a live instruction presented.
    drive_idle();
    rst = 1; ex_valid = 1; alu_result = 16'h1234; ex_reg_write = 1; ex_set_flags = 1; alu_flag_z = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("reset_cycle%0d", i), '0);
    end
    rst = 0;

    prev_o = '0;
    for (int i = 0; i < 31; i++) begin
      stall = vecs[i].stall; flush = vecs[i].flush; ex_valid = vecs[i].v;
      alu_result = vecs[i].alu; alu_flag_n = vecs[i].n; alu_flag_z = vecs[i].z;
      ex_set_flags = vecs[i].sf; ex_rd = vecs[i].rd; ex_reg_write = vecs[i].rw;
      ex_mem_read = vecs[i].mr; ex_mem_write = vecs[i].mw; ex_store_data = vecs[i].sd;
      ex_br_cond = vecs[i].cond; ex_br_target = vecs[i].tgt;
      step();
      if (vecs[i].stall) begin
        exp_o = prev_o;
      end else if (vecs[i].e_v) begin
        exp_o = '{1'b1, vecs[i].alu, vecs[i].sd, vecs[i].rd, vecs[i].rw, vecs[i].mr,
                  vecs[i].mw, 1'b0, vecs[i].tgt, 1'b0, 1'b0, 16'd0};
      end else begin
        exp_o = '0;
      end
      exp_o.bt = vecs[i].e_bt; exp_o.n = vecs[i].e_n; exp_o.z = vecs[i].e_z; exp_o.ret = vecs[i].e_ret;
      check($sformatf("vec%0d", i), exp_o);
      prev_o = exp_o;
    end

    // Reset dominates a simultaneous stall and flush.
    drive_idle();
    rst = 1; stall = 1; flush = 1; ex_valid = 1; alu_result = 16'h7777;
    step();
    check("reset_over_stall_flush", '0);
    drive_idle();
    rst = 0;

    // Counter wrap: FFFF accepts, then one more.
    ex_valid = 1; alu_result = 16'h0042; ex_rd = 4'h2; ex_reg_write = 1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    exp_o = '{1'b1, 16'h0042, 16'h0000, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF};
    check("count_ffff", exp_o);
    step();
    exp_o.ret = 16'h0000;
    check("count_wrap", exp_o);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
